// File: rtl/mem_target_if.sv
// Handshake bundle for mem_target: read-address/read-data and write channels.
// The target uses the slave modport; requesters use master.
interface mem_target_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_avalid;
    logic                  r_aready;
    logic                  r_dvalid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_ready;

    modport slave (
        input  r_addr, r_avalid, w_addr, w_data, w_valid,
        output r_aready, r_dvalid, r_data, w_ready
    );

    modport master (
        output r_addr, r_avalid, w_addr, w_data, w_valid,
        input  r_aready, r_dvalid, r_data, w_ready
    );
endinterface

// File: rtl/mem_target.sv
// Pipelined memory target: write-first storage, READ_LATENCY-deep read pipeline,
// accept counters. Define MEM_TARGET_BACKPRESSURE_EN for LFSR-driven ready stalls.
module mem_target #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MEM_DEPTH_LOG2 = 8,
    parameter int unsigned READ_LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    mem_target_if.slave bus,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);
    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;

    logic [MEM_DEPTH_LOG2-1:0] r_idx;
    logic [MEM_DEPTH_LOG2-1:0] w_idx;
    logic                      rd_acc;
    logic                      wr_acc;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

    logic r_aready_q, r_aready_d;
    logic w_ready_q, w_ready_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   data_d [READ_LATENCY];

    // Upper address bits deliberately ignored: addresses alias modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.r_addr, bus.w_addr};

    assign r_idx  = bus.r_addr[MEM_DEPTH_LOG2-1:0];
    assign w_idx  = bus.w_addr[MEM_DEPTH_LOG2-1:0];
    assign rd_acc = bus.r_avalid & r_aready_q;
    assign wr_acc = bus.w_valid & w_ready_q;

`ifdef MEM_TARGET_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        r_aready_d = lfsr_d[0];
        w_ready_d  = lfsr_d[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
`else
    always_comb begin
        r_aready_d = 1'b1;
        w_ready_d  = 1'b1;
    end
`endif

    // Write-first: a same-edge write to the read index bypasses storage.
    always_comb begin
        if (wr_acc && (w_idx == r_idx)) rd_word = bus.w_data;
        else                            rd_word = mem_q[r_idx];
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[w_idx] <= bus.w_data;
    end

    // Data stages only load when a valid token moves in, so the last stage
    // (r_data) holds its value between read responses.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = rd_acc;
        data_d[0]  = rd_acc ? rd_word : data_q[0];
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    always_comb begin
        rd_count_d = rd_count_q + 32'(rd_acc);
        wr_count_d = wr_count_q + 32'(wr_acc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            valid_q    <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            r_aready_q <= r_aready_d;
            w_ready_q  <= w_ready_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            valid_q    <= valid_d;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.r_aready = r_aready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.r_dvalid = valid_q[READ_LATENCY-1];
    assign bus.r_data   = data_q[READ_LATENCY-1];
    assign rd_count     = rd_count_q;
    assign wr_count     = wr_count_q;
endmodule

// File: tb/tb_mem_target.sv
// Directed bench for mem_target (DATA/ADDR 16, depth 2^8, READ_LATENCY 2).
// With MEM_TARGET_BACKPRESSURE_EN defined, runs a random handshake test against a model.
module tb_mem_target;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;

    mem_target_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    mem_target #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (16),
        .MEM_DEPTH_LOG2(8),
        .READ_LATENCY  (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

`ifdef MEM_TARGET_BACKPRESSURE_EN
    logic [15:0] model [16];
    bit          written [16];
    logic [15:0] exp_q [$];
    logic [15:0] exp_word;
    logic [3:0]  ra;
    int unsigned issued, cycles, n_rd, n_wr;
    logic        rd_acc, wr_acc;
`endif

    initial begin
        reset_n     = 1'b0;
        bus.r_addr  = '0;
        bus.r_avalid = 1'b0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        bus.w_valid = 1'b0;
        repeat (3) step();

        check("rst_r_aready", 64'(bus.r_aready), 64'd0);
        check("rst_w_ready",  64'(bus.w_ready),  64'd0);
        check("rst_r_dvalid", 64'(bus.r_dvalid), 64'd0);
        check("rst_r_data",   64'(bus.r_data),   64'd0);
        check("rst_rd_count", 64'(rd_count),     64'd0);
        check("rst_wr_count", 64'(wr_count),     64'd0);

        reset_n = 1'b1;
        step();

`ifdef MEM_TARGET_BACKPRESSURE_EN
        issued = 0; cycles = 0; n_rd = 0; n_wr = 0;
        for (int i = 0; i < 16; i++) written[i] = 1'b0;
        while (issued < 1000 && cycles < 20000) begin
            if (!bus.w_valid && ($urandom_range(0, 1) == 1)) begin
                bus.w_addr  = {8'($urandom), 4'h0, 4'($urandom)};
                bus.w_data  = 16'($urandom);
                bus.w_valid = 1'b1;
                issued++;
            end
            if (!bus.r_avalid && ($urandom_range(0, 1) == 1)) begin
                ra = 4'($urandom);
                if (written[ra]) begin
                    bus.r_addr   = {8'($urandom), 4'h0, ra};
                    bus.r_avalid = 1'b1;
                    issued++;
                end
            end
            rd_acc = bus.r_avalid && bus.r_aready;
            wr_acc = bus.w_valid && bus.w_ready;
            if (rd_acc) begin
                if (wr_acc && (bus.w_addr[7:0] == bus.r_addr[7:0])) exp_word = bus.w_data;
                else                                                exp_word = model[bus.r_addr[3:0]];
                exp_q.push_back(exp_word);
                n_rd++;
            end
            if (wr_acc) begin
                model[bus.w_addr[3:0]]   = bus.w_data;
                written[bus.w_addr[3:0]] = 1'b1;
                n_wr++;
            end
            step();
            cycles++;
            if (rd_acc) bus.r_avalid = 1'b0;
            if (wr_acc) bus.w_valid  = 1'b0;
            if (bus.r_dvalid) begin
                check("rnd_expected_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check("rnd_r_data", 64'(bus.r_data), 64'(exp_q.pop_front()));
            end
        end
        check("rnd_cycle_budget", 64'(cycles < 20000), 64'd1);
        // Hold any outstanding requests until accepted, then drain the pipeline.
        for (int i = 0; i < 200 && (bus.r_avalid || bus.w_valid || exp_q.size() > 0); i++) begin
            rd_acc = bus.r_avalid && bus.r_aready;
            wr_acc = bus.w_valid && bus.w_ready;
            if (rd_acc) begin
                if (wr_acc && (bus.w_addr[7:0] == bus.r_addr[7:0])) exp_word = bus.w_data;
                else                                                exp_word = model[bus.r_addr[3:0]];
                exp_q.push_back(exp_word);
                n_rd++;
            end
            if (wr_acc) begin
                model[bus.w_addr[3:0]] = bus.w_data;
                n_wr++;
            end
            step();
            if (rd_acc) bus.r_avalid = 1'b0;
            if (wr_acc) bus.w_valid  = 1'b0;
            if (bus.r_dvalid) begin
                check("drn_expected_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check("drn_r_data", 64'(bus.r_data), 64'(exp_q.pop_front()));
            end
        end
        check("rnd_all_returned", 64'(exp_q.size()), 64'd0);
        check("rnd_rd_count", 64'(rd_count), 64'(n_rd));
        check("rnd_wr_count", 64'(wr_count), 64'(n_wr));
`else
        check("rel_r_aready", 64'(bus.r_aready), 64'd1);
        check("rel_w_ready",  64'(bus.w_ready),  64'd1);

        // write 0x0010 <- BEEF, then read it back with latency 2
        bus.w_addr = 16'h0010; bus.w_data = 16'hBEEF; bus.w_valid = 1'b1;
        step();
        bus.w_valid = 1'b0;
        check("wr_count_1", 64'(wr_count), 64'd1);
        bus.r_addr = 16'h0010; bus.r_avalid = 1'b1;
        step();
        bus.r_avalid = 1'b0;
        check("beef_lat1_dvalid", 64'(bus.r_dvalid), 64'd0);
        step();
        check("beef_lat2_dvalid", 64'(bus.r_dvalid), 64'd1);
        check("beef_data",        64'(bus.r_data),   64'hBEEF);
        check("rd_count_1",       64'(rd_count),     64'd1);
        step();
        check("beef_one_pulse",   64'(bus.r_dvalid), 64'd0);
        check("beef_data_hold",   64'(bus.r_data),   64'hBEEF);

        // preload 0..7 and stream 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            bus.w_addr = 16'(i); bus.w_data = 16'(16'h1000 + i); bus.w_valid = 1'b1;
            step();
        end
        bus.w_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.r_addr = 16'(i); bus.r_avalid = 1'b1;
            end else begin
                bus.r_avalid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 8) begin
                check($sformatf("burst_dvalid%0d", i - 1), 64'(bus.r_dvalid), 64'd1);
                check($sformatf("burst_data%0d", i - 1),   64'(bus.r_data),   64'(16'h1000 + i - 1));
            end else begin
                check($sformatf("burst_idle%0d", i), 64'(bus.r_dvalid), 64'd0);
            end
        end
        check("rd_count_9", 64'(rd_count), 64'd9);
        check("wr_count_9", 64'(wr_count), 64'd9);

        // same-edge write and read to index 5: write-first
        bus.w_addr = 16'h0005; bus.w_data = 16'h1234; bus.w_valid = 1'b1;
        bus.r_addr = 16'h0005; bus.r_avalid = 1'b1;
        step();
        bus.w_valid = 1'b0; bus.r_avalid = 1'b0;
        step();
        check("wf_dvalid", 64'(bus.r_dvalid), 64'd1);
        check("wf_data",   64'(bus.r_data),   64'h1234);

        // aliasing: 0x0103 and 0x0003 share index 3
        bus.w_addr = 16'h0103; bus.w_data = 16'h00AA; bus.w_valid = 1'b1;
        step();
        bus.w_valid = 1'b0;
        bus.r_addr = 16'h0003; bus.r_avalid = 1'b1;
        step();
        bus.r_avalid = 1'b0;
        step();
        check("alias_dvalid", 64'(bus.r_dvalid), 64'd1);
        check("alias_data",   64'(bus.r_data),   64'h00AA);
        check("rd_count_11",  64'(rd_count),     64'd11);
        check("wr_count_11",  64'(wr_count),     64'd11);

        // reset one cycle after a read accept discards the read
        bus.r_addr = 16'h0010; bus.r_avalid = 1'b1;
        step();
        bus.r_avalid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_dvalid",   64'(bus.r_dvalid), 64'd0);
        check("mid_rst_data",     64'(bus.r_data),   64'd0);
        check("mid_rst_rd_count", 64'(rd_count),     64'd0);
        check("mid_rst_r_aready", 64'(bus.r_aready), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst_no_dvalid%0d", i), 64'(bus.r_dvalid), 64'd0);
        end
        check("post_rst_rd_count", 64'(rd_count), 64'd0);
        check("post_rst_wr_count", 64'(wr_count), 64'd0);
        bus.r_addr = 16'h0010; bus.r_avalid = 1'b1;
        step();
        bus.r_avalid = 1'b0;
        step();
        check("retained_dvalid", 64'(bus.r_dvalid), 64'd1);
        check("retained_data",   64'(bus.r_data),   64'hBEEF);
        check("retained_rd_count", 64'(rd_count),   64'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
